// File: rtl/act_seg_select_if.sv
// Sample stream into act_seg_select and the coefficient/clamp stream it feeds to linear_fun.
// Pure wiring with no storage, so it adds no latency.
// The stream has no backpressure: the slave takes every valid sample, and the master takes every output.
interface act_seg_select_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COE_A_WIDTH = 8,
    parameter int COE_B_WIDTH = 16
);
    // upstream sample stream
    logic                               i_dat_vld;
    logic [DATA_WIDTH-1:0]              i_dat;
    logic                               i_last;

    // downstream stream, aligned for linear_fun
    logic                               o_vld;
    logic [DATA_WIDTH-1:0]              o_dat;
    logic [COE_A_WIDTH+COE_B_WIDTH-1:0] o_act_coe;
    logic                               o_max_value_en;
    logic                               o_min_value_en;
    logic [DATA_WIDTH-1:0]              o_max_value;
    logic [DATA_WIDTH-1:0]              o_min_value;

    // segment selector side
    modport slave (
        input  i_dat_vld, i_dat, i_last,
        output o_vld, o_dat, o_act_coe, o_max_value_en, o_min_value_en,
               o_max_value, o_min_value
    );

    // producer / consumer side
    modport master (
        output i_dat_vld, i_dat, i_last,
        input  o_vld, o_dat, o_act_coe, o_max_value_en, o_min_value_en,
               o_max_value, o_min_value
    );
endinterface

// File: rtl/act_seg_select.sv
// Piecewise-linear segment selector: it picks the {a,b} coefficients and the clamp enables for each signed sample.
// Latency is 2 cycles from an accepted sample to o_vld; a start/drain FSM frames each run.
// There is no backpressure: every sample in RUN is accepted, and the optional counters are enabled by ACT_SEG_CNT_EN.
module act_seg_select #(
    parameter int DATA_WIDTH  = 8,
    parameter int COE_A_WIDTH = 8,
    parameter int COE_B_WIDTH = 16,
    parameter int SEG_NUM     = 8,
    parameter int ADDR_W      = 5
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_cfg_we,
    input  logic [ADDR_W-1:0]                  i_cfg_addr,
    input  logic [COE_A_WIDTH+COE_B_WIDTH-1:0] i_cfg_wdata,
    output logic                               o_cfg_err,
    input  logic                               i_start,
    output logic                               o_busy,
    output logic                               o_done,
    act_seg_select_if.slave                    bus,
    output logic [15:0]                        o_max_cnt,
    output logic [15:0]                        o_min_cnt
);

    localparam int COE_W  = COE_A_WIDTH + COE_B_WIDTH;
    localparam int BP_NUM = SEG_NUM - 1;
    localparam int IDX_W  = $clog2(SEG_NUM);

    // config map boundaries
    localparam logic [ADDR_W-1:0] ADDR_BP_END   = ADDR_W'(BP_NUM);
    localparam logic [ADDR_W-1:0] ADDR_COEF_LO  = ADDR_W'(SEG_NUM);
    localparam logic [ADDR_W-1:0] ADDR_COEF_END = ADDR_W'(2 * SEG_NUM);
    localparam logic [ADDR_W-1:0] ADDR_MAX      = ADDR_W'(2 * SEG_NUM);
    localparam logic [ADDR_W-1:0] ADDR_MIN      = ADDR_W'(2 * SEG_NUM + 1);

    localparam logic signed [DATA_WIDTH-1:0] MAX_RST = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_RST = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // run control FSM
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0] state;
    logic       drain_cnt;
    logic       start_ok;
    logic       accept;

    // config table
    logic signed [DATA_WIDTH-1:0] bp [BP_NUM];
    logic [COE_W-1:0]             coef [SEG_NUM];
    logic signed [DATA_WIDTH-1:0] max_val;
    logic signed [DATA_WIDTH-1:0] min_val;

    logic             hit_bp;
    logic             hit_coef;
    logic             hit_max;
    logic             hit_min;
    logic             cfg_wr;
    logic             cfg_err_nxt;
    logic [IDX_W-1:0] wr_idx;

    // stage 1
    logic signed [DATA_WIDTH-1:0] din;
    logic [BP_NUM-1:0]            ge;
    logic                         max_hit;
    logic                         min_hit;
    logic                         s1_vld;
    logic [BP_NUM-1:0]            s1_ge;
    logic [DATA_WIDTH-1:0]        s1_dat;
    logic                         s1_max;
    logic                         s1_min;

    // stage 2
    logic [IDX_W-1:0]      seg_idx;
    logic [COE_W-1:0]      coef_sel;
    logic                  out_vld;
    logic [DATA_WIDTH-1:0] out_dat;
    logic [COE_W-1:0]      out_coe;
    logic                  out_max_en;
    logic                  out_min_en;

    assign start_ok = i_start && (state == ST_IDLE);
    assign accept   = bus.i_dat_vld && (state == ST_RUN);
    assign o_busy   = (state != ST_IDLE);

    // IDLE waits for start, RUN waits for the last sample, and DRAIN lets the 2-stage pipe empty
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.i_dat_vld && bus.i_last) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // done is registered one cycle early so it lands with the last o_vld
                    if (drain_cnt == 1'b0) begin
                        drain_cnt <= 1'b1;
                        o_done    <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // decode config address, and reject unmapped addresses or any write outside IDLE
    always_comb begin
        hit_bp      = (i_cfg_addr < ADDR_BP_END);
        hit_coef    = (i_cfg_addr >= ADDR_COEF_LO) && (i_cfg_addr < ADDR_COEF_END);
        hit_max     = (i_cfg_addr == ADDR_MAX);
        hit_min     = (i_cfg_addr == ADDR_MIN);
        cfg_wr      = i_cfg_we && (state == ST_IDLE);
        cfg_err_nxt = i_cfg_we &&
                      ((state != ST_IDLE) || !(hit_bp || hit_coef || hit_max || hit_min));
        // SEG_NUM is a power of two, so the low bits index both the breakpoints and the coefficients
        wr_idx      = i_cfg_addr[IDX_W-1:0];
    end

    // config table storage, which reset returns to its defaults
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < BP_NUM; k++) begin
                bp[k] <= '0;
            end
            for (int k = 0; k < SEG_NUM; k++) begin
                coef[k] <= '0;
            end
            max_val <= MAX_RST;
            min_val <= MIN_RST;
        end else if (cfg_wr) begin
            if (hit_bp) begin
                bp[wr_idx] <= i_cfg_wdata[DATA_WIDTH-1:0];
            end
            if (hit_coef) begin
                coef[wr_idx] <= i_cfg_wdata;
            end
            if (hit_max) begin
                max_val <= i_cfg_wdata[DATA_WIDTH-1:0];
            end
            if (hit_min) begin
                min_val <= i_cfg_wdata[DATA_WIDTH-1:0];
            end
        end
    end

    // report a rejected write one cycle after it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cfg_err <= 1'b0;
        end else begin
            o_cfg_err <= cfg_err_nxt;
        end
    end

    assign din = bus.i_dat;

    // compare the sample against every breakpoint and both clamps, with max taking priority
    always_comb begin
        ge = '0;
        for (int k = 0; k < BP_NUM; k++) begin
            ge[k] = (din >= bp[k]);
        end
        max_hit = (din >= max_val);
        min_hit = !max_hit && (din <= min_val);
    end

    // stage 1 registers the compare results and the sample
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld <= 1'b0;
            s1_ge  <= '0;
            s1_dat <= '0;
            s1_max <= 1'b0;
            s1_min <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_ge  <= ge;
                s1_dat <= bus.i_dat;
                s1_max <= max_hit;
                s1_min <= min_hit;
            end
        end
    end

    // the thermometer count of passed breakpoints gives the segment index, which selects the coefficient word
    always_comb begin
        seg_idx = '0;
        for (int k = 0; k < BP_NUM; k++) begin
            seg_idx = seg_idx + IDX_W'(s1_ge[k]);
        end
        coef_sel = coef[seg_idx];
    end

    // stage 2 output registers, where data holds while idle and the enables are qualified by valid
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_vld    <= 1'b0;
            out_dat    <= '0;
            out_coe    <= '0;
            out_max_en <= 1'b0;
            out_min_en <= 1'b0;
        end else begin
            out_vld    <= s1_vld;
            out_max_en <= s1_vld && s1_max;
            out_min_en <= s1_vld && s1_min;
            if (s1_vld) begin
                out_dat <= s1_dat;
                out_coe <= coef_sel;
            end
        end
    end

    assign bus.o_vld          = out_vld;
    assign bus.o_dat          = out_dat;
    assign bus.o_act_coe      = out_coe;
    assign bus.o_max_value_en = out_max_en;
    assign bus.o_min_value_en = out_min_en;
    assign bus.o_max_value    = max_val;
    assign bus.o_min_value    = min_val;

`ifdef ACT_SEG_CNT_EN
    logic [15:0] max_cnt;
    logic [15:0] min_cnt;

    // saturating clamp-event counters, cleared when a new run is accepted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            max_cnt <= '0;
            min_cnt <= '0;
        end else if (start_ok) begin
            max_cnt <= '0;
            min_cnt <= '0;
        end else begin
            if (out_vld && out_max_en && (max_cnt != 16'hFFFF)) begin
                max_cnt <= max_cnt + 16'd1;
            end
            if (out_vld && out_min_en && (min_cnt != 16'hFFFF)) begin
                min_cnt <= min_cnt + 16'd1;
            end
        end
    end

    assign o_max_cnt = max_cnt;
    assign o_min_cnt = min_cnt;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign o_max_cnt       = '0;
    assign o_min_cnt       = '0;
`endif

endmodule

// File: tb/tb_act_seg_select.sv
// Directed bench for act_seg_select: it checks config, segment selection, clamps, run framing and the counters.
module tb_act_seg_select;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [23:0] cfg_wdata;
    logic        cfg_err;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] max_cnt;
    logic [15:0] min_cnt;

    int total = 0;
    int bad   = 0;

    act_seg_select_if #(.DATA_WIDTH(8), .COE_A_WIDTH(8), .COE_B_WIDTH(16)) bus ();

    act_seg_select #(
        .DATA_WIDTH(8), .COE_A_WIDTH(8), .COE_B_WIDTH(16), .SEG_NUM(8), .ADDR_W(5)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cfg_we    (cfg_we),
        .i_cfg_addr  (cfg_addr),
        .i_cfg_wdata (cfg_wdata),
        .o_cfg_err   (cfg_err),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .bus         (bus),
        .o_max_cnt   (max_cnt),
        .o_min_cnt   (min_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // samples with hand-derived segment and clamp flags (bp -96..96 step 32, max 100, min -100)
    int sv    [10] = '{40, -100, 96, 32, 31, -128, 127, 0, 100, 120};
    int seg   [10] = '{5,  0,    7,  5,  4,  0,    7,   4, 7,   7};
    int e_max [10] = '{0,  0,    0,  0,  0,  0,    1,   0, 1,   1};
    int e_min [10] = '{0,  1,    0,  0,  0,  1,    0,   0, 0,   0};

    function automatic logic [23:0] coef_of(input int k);
        if (k == 5) return 24'h020100;
        return {8'(16 + k), 16'(4096 + k)};
    endfunction

    function automatic logic [31:0] b8(input int v);
        return {24'h0, 8'(v)};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [23:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = 5'(addr);
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // drives one sample, then returns when it is on the output
    task automatic send_one(input int d, input logic last);
        bus.i_dat_vld = 1'b1;
        bus.i_dat     = 8'(d);
        bus.i_last    = last;
        tick();
        bus.i_dat_vld = 1'b0;
        bus.i_last    = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
        bus.i_dat_vld = 1'b0; bus.i_dat = '0; bus.i_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        check("rst_max_value", b8(bus.o_max_value), 32'h7F);
        check("rst_min_value", b8(bus.o_min_value), 32'h80);
        check("rst_vld",       32'(bus.o_vld), 32'h0);
        check("rst_busy",      32'(busy), 32'h0);
        check("rst_done",      32'(done), 32'h0);
        check("rst_cfg_err",   32'(cfg_err), 32'h0);
        check("rst_coe",       32'(bus.o_act_coe), 32'h0);
        check("rst_max_cnt",   32'(max_cnt), 32'h0);

        // program the table
        for (int k = 0; k < 7; k++) wr(k, 24'(-96 + 32 * k));
        for (int k = 0; k < 8; k++) wr(8 + k, coef_of(k));
        wr(16, 24'd100);
        wr(17, 24'(-100));
        check("cfg_ok_no_err", 32'(cfg_err), 32'h0);
        check("cfg_max_value", b8(bus.o_max_value), b8(100));
        check("cfg_min_value", b8(bus.o_min_value), b8(-100));

        wr(7, 24'h123456);
        check("cfg_addr7_err", 32'(cfg_err), 32'h1);
        tick();
        check("cfg_err_pulse", 32'(cfg_err), 32'h0);
        wr(18, 24'h000001);
        check("cfg_addr18_err", 32'(cfg_err), 32'h1);
        tick();

        // segment and clamp selection
        pulse_start();
        check("run_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 10; i++) begin
            send_one(sv[i], 1'b0);
            check($sformatf("seg_vld_%0d", sv[i]),  32'(bus.o_vld), 32'h1);
            check($sformatf("seg_dat_%0d", sv[i]),  b8(bus.o_dat), b8(sv[i]));
            check($sformatf("seg_coe_%0d", sv[i]),  32'(bus.o_act_coe), 32'(coef_of(seg[i])));
            check($sformatf("seg_max_%0d", sv[i]),  32'(bus.o_max_value_en), 32'(e_max[i]));
            check($sformatf("seg_min_%0d", sv[i]),  32'(bus.o_min_value_en), 32'(e_min[i]));
        end
        tick();
        check("idle_vld_low",   32'(bus.o_vld), 32'h0);
        check("idle_max_en_0",  32'(bus.o_max_value_en), 32'h0);
        check("idle_dat_hold",  b8(bus.o_dat), b8(120));
        check("idle_coe_hold",  32'(bus.o_act_coe), 32'(coef_of(7)));

        // a write during RUN is rejected and bp3 is unchanged
        wr(3, 24'h000050);
        check("run_wr_err", 32'(cfg_err), 32'h1);
        send_one(0, 1'b0);
        check("bp3_unchanged", 32'(bus.o_act_coe), 32'(coef_of(4)));

        // the last sample ends the run, and done coincides with its output
        send_one(5, 1'b1);
        check("end_vld",  32'(bus.o_vld), 32'h1);
        check("end_done", 32'(done), 32'h1);
        check("end_coe",  32'(bus.o_act_coe), 32'(coef_of(4)));
        tick();
        check("end_busy_drop", 32'(busy), 32'h0);
        check("end_done_pulse", 32'(done), 32'h0);

        // 4-sample back-to-back run, where a start during the done cycle is ignored
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            bus.i_dat_vld = (i < 4);
            bus.i_dat     = 8'(10 * (i + 1));
            bus.i_last    = (i == 3);
            start         = (i == 5);
            tick();
            check($sformatf("b2b_vld_%0d", i), 32'(bus.o_vld), 32'((i >= 1) && (i <= 4)));
            if ((i >= 1) && (i <= 4)) check($sformatf("b2b_dat_%0d", i), b8(bus.o_dat), b8(10 * i));
            check($sformatf("b2b_done_%0d", i), 32'(done), 32'(i == 4));
            check($sformatf("b2b_busy_%0d", i), 32'(busy), 32'(i < 5));
        end
        start = 1'b0;
        bus.i_dat_vld = 1'b0;
        bus.i_last    = 1'b0;

        // a valid sample in IDLE is ignored
        bus.i_dat_vld = 1'b1;
        bus.i_dat     = 8'd50;
        tick();
        bus.i_dat_vld = 1'b0;
        tick();
        check("idle_in_no_vld_a", 32'(bus.o_vld), 32'h0);
        tick();
        check("idle_in_no_vld_b", 32'(bus.o_vld), 32'h0);

        // clamp-event counters
        pulse_start();
        send_one(110, 1'b0);
        send_one(-110, 1'b0);
        send_one(100, 1'b0);
        send_one(127, 1'b0);
        send_one(-128, 1'b0);
        send_one(5, 1'b1);
        tick();
`ifdef ACT_SEG_CNT_EN
        check("cnt_max", 32'(max_cnt), 32'd3);
        check("cnt_min", 32'(min_cnt), 32'd2);
        pulse_start();
        check("cnt_max_clr", 32'(max_cnt), 32'd0);
        check("cnt_min_clr", 32'(min_cnt), 32'd0);
        send_one(0, 1'b1);
        tick();
`else
        check("cnt_max_tied", 32'(max_cnt), 32'd0);
        check("cnt_min_tied", 32'(min_cnt), 32'd0);
`endif
        check("cnt_run_idle", 32'(busy), 32'h0);

        // reset in the middle of a run
        pulse_start();
        bus.i_dat_vld = 1'b1;
        bus.i_dat     = 8'd120;
        tick();
        bus.i_dat_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_busy",      32'(busy), 32'h0);
        check("mrst_vld",       32'(bus.o_vld), 32'h0);
        check("mrst_max_value", b8(bus.o_max_value), 32'h7F);
        check("mrst_min_value", b8(bus.o_min_value), 32'h80);
        tick();
        rst_n = 1'b1;
        tick();
        check("mrst_no_done", 32'(done), 32'h0);
        check("mrst_no_vld",  32'(bus.o_vld), 32'h0);
        check("mrst_coe_clr", 32'(bus.o_act_coe), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
